// File: rtl/sdram_init_refresh_pkg.sv
// Shared SDRAM command encodings, constants and init-FSM state type.
package sdram_init_refresh_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NOP = 3'd0;
    localparam logic [CMD_W-1:0] CMD_PRE = 3'd1;
    localparam logic [CMD_W-1:0] CMD_REF = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LMR = 3'd3;

    // A10 high selects all banks for PRECHARGE
    localparam logic [12:0] A10_ALL_BANKS = 13'h0400;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_PRE,
        ST_WAIT_RP,
        ST_REF,
        ST_WAIT_RFC,
        ST_LMR,
        ST_WAIT_MRD,
        ST_DONE
    } init_state_t;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_refresh_if.sv
// Sequencer <-> memory arbiter bundle: init commands plus refresh handshake.
interface sdram_init_refresh_if;
    import sdram_init_refresh_pkg::*;

    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic [12:0]      mode_addr;
    logic             init_done;
    logic             ref_req;
    logic             ref_ack;
    logic             ref_overrun;

    modport master (
        output cmd, cmd_valid, mode_addr, init_done, ref_req, ref_overrun,
        input  ref_ack
    );

    modport slave (
        input  cmd, cmd_valid, mode_addr, init_done, ref_req, ref_overrun,
        output ref_ack
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// Post-init refresh timer: interval counter, saturating pending count, overrun flag.
module sdram_ref_timer
    import sdram_init_refresh_pkg::*;
#(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_overrun
);
    localparam int IW = $clog2(REF_INTERVAL + 1);

    logic [IW-1:0] ivl;
    logic [2:0]    pend;
    logic          tick;
    logic          ack_ok;

    // Acks with nothing pending (or before init completes) are dropped
    assign tick   = en && (ivl == IW'(REF_INTERVAL - 1));
    assign ack_ok = en && ref_ack && (pend != 3'd0);

    // Interval counter: held at 0 until init_done, then free-runs and wraps on tick
    always_ff @(posedge clk) begin
        if (rst || !en)
            ivl <= '0;
        else if (tick)
            ivl <= '0;
        else
            ivl <= ivl + IW'(1);
    end

    // Pending count: tick and ack together cancel; a tick at 7 is lost and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= 3'd0;
            ref_overrun <= 1'b0;
            ref_req     <= 1'b0;
        end else begin
            if (tick && !ack_ok) begin
                if (pend == 3'd7)
                    ref_overrun <= 1'b1;
                else
                    pend <= pend + 3'd1;
            end else if (ack_ok && !tick) begin
                pend <= pend - 3'd1;
            end
            ref_req <= (pend != 3'd0);
        end
    end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up/init command sequencer; hands off to the refresh timer once done.
module sdram_init_refresh
    import sdram_init_refresh_pkg::*;
#(
    parameter int          PWRUP_CYCLES = 20000,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          NUM_INIT_REF = 8,
    parameter int          REF_INTERVAL = 780,
    parameter logic [12:0] MODE_VALUE   = 13'h0022
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_init_refresh_if.master bus
);
    localparam int DLY_MAX = max2(max2(PWRUP_CYCLES, T_RP), max2(T_RFC, T_MRD));
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int REF_W   = 4;

    init_state_t      state, state_nx;
    logic [DLY_W-1:0] dly, dly_nx;
    logic [REF_W-1:0] nref, nref_nx;
    logic [CMD_W-1:0] cmd_nx;
    logic [12:0]      addr_nx;
    logic             init_done;
    logic             ref_req;
    logic             ref_overrun;

    // Next state: shared delay counter counts up from 0 after every state entry
    always_comb begin
        state_nx = state;
        dly_nx   = dly + DLY_W'(1);
        nref_nx  = nref;
        case (state)
            ST_PWRUP:
                if (dly == DLY_W'(PWRUP_CYCLES - 1)) begin
                    state_nx = ST_PRE;
                    dly_nx   = '0;
                end
            ST_PRE: begin
                state_nx = ST_WAIT_RP;
                dly_nx   = '0;
            end
            ST_WAIT_RP:
                if (dly == DLY_W'(T_RP - 1)) begin
                    state_nx = ST_REF;
                    dly_nx   = '0;
                end
            ST_REF: begin
                state_nx = ST_WAIT_RFC;
                dly_nx   = '0;
                nref_nx  = nref + REF_W'(1);
            end
            ST_WAIT_RFC:
                if (dly == DLY_W'(T_RFC - 1)) begin
                    state_nx = (nref == REF_W'(NUM_INIT_REF)) ? ST_LMR : ST_REF;
                    dly_nx   = '0;
                end
            ST_LMR: begin
                state_nx = ST_WAIT_MRD;
                dly_nx   = '0;
            end
            ST_WAIT_MRD:
                if (dly == DLY_W'(T_MRD - 1)) begin
                    state_nx = ST_DONE;
                    dly_nx   = '0;
                end
            ST_DONE:
                dly_nx = '0;
            default: begin
                state_nx = ST_PWRUP;
                dly_nx   = '0;
            end
        endcase

        // Outputs decoded from the next state so they register in step with it
        cmd_nx  = CMD_NOP;
        addr_nx = '0;
        case (state_nx)
            ST_PRE: begin
                cmd_nx  = CMD_PRE;
                addr_nx = A10_ALL_BANKS;
            end
            ST_REF: cmd_nx = CMD_REF;
            ST_LMR: begin
                cmd_nx  = CMD_LMR;
                addr_nx = MODE_VALUE;
            end
            default: ;
        endcase
    end

    // State, counters and registered command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_PWRUP;
            dly           <= '0;
            nref          <= '0;
            bus.cmd       <= CMD_NOP;
            bus.cmd_valid <= 1'b0;
            bus.mode_addr <= '0;
            init_done     <= 1'b0;
        end else begin
            state         <= state_nx;
            dly           <= dly_nx;
            nref          <= nref_nx;
            bus.cmd       <= cmd_nx;
            bus.cmd_valid <= (cmd_nx != CMD_NOP);
            bus.mode_addr <= addr_nx;
            init_done     <= (state_nx == ST_DONE);
        end
    end

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (init_done),
        .ref_ack    (bus.ref_ack),
        .ref_req    (ref_req),
        .ref_overrun(ref_overrun)
    );

    assign bus.init_done   = init_done;
    assign bus.ref_req     = ref_req;
    assign bus.ref_overrun = ref_overrun;

endmodule
